button_conditioner: RTL
=======================

# button_conditioner

Upstream input stage for the up/down display counter FSM. It takes the two raw push-button levels, synchronises and debounces them in the `dclk` domain, and merges near-simultaneous presses into one command. Each accepted press produces exactly one `dclk` cycle on `up`, on `down`, or on both together (the "clear" command). The counter FSM consumes `up`/`down` directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive `dclk` cycles a synchronised level must hold before the debounced level changes. Must be ≥1.
- `CNT_W`, default 3: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `COMBO_WINDOW`, default 3: `dclk` cycles spent waiting for the second button after the first is seen. Must be ≥1.
- `ACTIVE_LOW`, default 0: 1 means a raw input of 0 is "pressed".

Ports:
- `dclk` input 1: divided system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `btn_up_raw` input 1: raw up button, asynchronous to `dclk`.
- `btn_down_raw` input 1: raw down button, asynchronous to `dclk`.
- `up` output 1: one-cycle increment command, registered.
- `down` output 1: one-cycle decrement command, registered. `up` and `down` high in the same cycle means clear.
- `up_level` output 1: debounced up level, active-high.
- `down_level` output 1: debounced down level, active-high.

## Operation
- **Polarity:** the raw input is XORed with `ACTIVE_LOW` before the synchroniser, so everything internal is active-high.
- **Synchroniser:** two flops per button.
- **Debouncer (per button):**
  - Debounced level `db` and counter `cnt`.
  - When the synchronised value equals `db`, `cnt` is 0.
  - When it differs, `cnt` increments every cycle.
  - On the cycle `cnt` would reach `DEBOUNCE_CYCLES`, `db` toggles and `cnt` returns to 0.
  - Any return to agreement before that clears `cnt`.
- **FSM states:** IDLE, WAIT, EMIT, HOLD. `up` and `down` are registered and asserted only in EMIT.
  - **IDLE:**
    - If both `db` are high, go to EMIT with up=down=1.
    - If exactly one is high, record it as `first`, clear the window counter `win`, and go to WAIT.
  - **WAIT:** `win` increments each cycle. The other button's `db` is sampled at every WAIT edge.
    - If the other `db` is high, go to EMIT with both set.
    - Otherwise, when `win` == COMBO_WINDOW−1, go to EMIT with only `first` set.
    - Release of `first` during WAIT does not cancel the command.
  - **EMIT:** lasts exactly one cycle, then HOLD.
  - **HOLD:** stay until both `db` are low, then go to IDLE. Presses during HOLD are ignored, so a held button never repeats.
- **Reset values:**
  - Synchroniser flops, `db`, `cnt`, and `win` are 0.
  - `up`, `down`, `up_level`, `down_level` are 0.
  - FSM state is HOLD, so buttons held through reset produce no command until both are released.
  - Reset mid-WAIT or mid-EMIT aborts the pending command; no output is generated for it.

## Timing
- Raw edge first sampled at edge k:
  - synchronised output changes at edge k+1;
  - `db` (`up_level`/`down_level`) changes at edge k+1+DEBOUNCE_CYCLES.
- Single press with `db` rising at edge t:
  - WAIT entered at t+1;
  - EMIT entered at t+1+COMBO_WINDOW;
  - output high from that edge until the next edge.
- Defaults (N=4, W=3): a raw press stable from edge 0 gives `up`=1 between edges 9 and 10.
- Combo acceptance: the second `db` must rise no later than the last WAIT edge, i.e. within COMBO_WINDOW−1 cycles of the first `db` rising. Otherwise it is ignored until HOLD exits.
- Minimum spacing between two commands: 3 cycles (EMIT, HOLD, IDLE).
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no `db` change and no command.

## Test plan
All scenarios use defaults (N=4, W=3) unless stated.
1. **Glitch rejection:** reset, then pulse `btn_up_raw` high for 3 cycles → `up_level`, `up`, `down` stay 0 throughout.
2. **Single press:** hold `btn_up_raw` high for 30 cycles from edge 0 →
   - `up_level`=1 from edge 5;
   - `up`=1 only during edge 9–10;
   - `down`=0;
   - no further `up` until released and pressed again.
3. **Combo within window:** raise `btn_down_raw` at edge 0 and `btn_up_raw` at edge 2, hold both for 20 cycles → exactly one cycle with `up`=`down`=1, no single-button pulse.
4. **Combo outside window:** raise `btn_up_raw` at edge 0 and `btn_down_raw` at edge 6 →
   - `up` pulses once, `down` never pulses;
   - after both are released and `btn_down_raw` is pressed alone, `down` pulses once.
5. **Held through reset:** hold `btn_up_raw` high, assert `reset` for 2 cycles mid-WAIT, then release reset →
   - outputs 0 during and after reset;
   - no `up` until the button is released and re-pressed.
6. **Active-low polarity:** set `ACTIVE_LOW`=1, idle raw inputs at 1, drive `btn_down_raw` to 0 and hold → `down` pulses once, at the same latency as scenario 2.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end for the up/down counter: synchronise, debounce and merge
// near-simultaneous presses into one-cycle up / down / clear (both) commands.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int COMBO_WINDOW    = 3,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic dclk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic up_level,
  output logic down_level
);

  localparam int WIN_W = (COMBO_WINDOW > 1) ? $clog2(COMBO_WINDOW) : 1;
  localparam int SET_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(COMBO_WINDOW - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(DEBOUNCE_CYCLES + 3);
  localparam logic             POL         = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, WAIT, EMIT, HOLD} state_t;

  // bit 0 is the up button, bit 1 the down button throughout
  logic [1:0]       raw, sync1, sync2, db;
  logic [CNT_W-1:0] cnt [2];
  logic [SET_W-1:0] settle;
  logic             ready;

  state_t           state, state_n;
  logic [WIN_W-1:0] win, win_n;
  logic             first, first_n;
  logic             up_n, down_n;
  logic             other;

  assign raw = {btn_down_raw, btn_up_raw} ^ {2{POL}};

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // The debounced levels read low right after reset even for a held button, so
  // HOLD is kept until a held button has had time to debounce high again.
  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      settle <= '0;
    end else if (settle != SETTLE_LAST) begin
      settle <= settle + SET_W'(1);
    end
  end

  assign ready = (settle == SETTLE_LAST);
  assign other = first ? db[0] : db[1];

  always_comb begin
    state_n = state;
    win_n   = win;
    first_n = first;
    up_n    = 1'b0;
    down_n  = 1'b0;
    case (state)
      IDLE: begin
        if (db == 2'b11) begin
          state_n = EMIT;
          up_n    = 1'b1;
          down_n  = 1'b1;
        end else if (db != 2'b00) begin
          first_n = db[1];
          win_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        win_n = win + WIN_W'(1);
        if (other) begin
          state_n = EMIT;
          up_n    = 1'b1;
          down_n  = 1'b1;
        end else if (win == WIN_LAST) begin
          state_n = EMIT;
          up_n    = ~first;
          down_n  = first;
        end
      end
      EMIT: state_n = HOLD;
      HOLD: begin
        if (ready && db == 2'b00) begin
          state_n = IDLE;
        end
      end
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      win   <= '0;
      first <= 1'b0;
      up    <= 1'b0;
      down  <= 1'b0;
    end else begin
      state <= state_n;
      win   <= win_n;
      first <= first_n;
      up    <= up_n;
      down  <= down_n;
    end
  end

  assign up_level   = db[0];
  assign down_level = db[1];

endmodule
